pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register for the in-order RV64 core. Replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries a data payload and a control payload between stages using a valid/ready handshake, so back-pressure from a stalled downstream stage needs no external gating.
- Supports synchronous flush (squash) and an optional 1-entry skid slot, which makes in_ready a registered signal and breaks the combinational ready path between stages.

Parameters:
- DATA_W, 197, total payload width (e.g. adder out 64 + ALU result 64 + store data 64 + rd 5 for EX/MEM).
- CTRL_W, 7, control-bit width (branch, memread, memtoreg, memwrite, regwrite, addermuxselect, zero).
- SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- CLEAR_DATA, 0, 1 = reset/flush also zero the data payload; 0 = data payload holds its value and only the valid and ctrl bits clear.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has an entry to hand over.
- in_ready  output  1  block can accept an entry this cycle.
- in_data  input  DATA_W  upstream data payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  the out_data/out_ctrl entry is valid.
- out_ready  input  1  downstream consumes the entry this cycle.
- out_data  output  DATA_W  registered data payload.
- out_ctrl  output  CTRL_W  registered control; forced to 0 whenever out_valid=0.
- occupancy  output  2  number of held entries, 0..2 (never exceeds 1 when SKID=0).

Behaviour:
- Handshake definitions:
  - An entry is accepted on a rising edge where in_valid && in_ready.
  - An entry is consumed on a rising edge where out_valid && out_ready.
- Reset, which takes priority over everything else:
  - out_valid=0, out_ctrl=0, occupancy=0, skid slot invalid.
  - in_ready=1 from the first cycle after reset.
  - out_data=0 if CLEAR_DATA=1; otherwise out_data is don't-care.
- Flush (when reset=0):
  - Same effect as reset on the next edge. Any accept or consume in the flush cycle is ignored; the in-flight input is dropped.
  - in_ready may be high during the flush cycle. Upstream must treat its entry as killed, since upstream is flushed by the same signal.
- Latency: an accepted entry appears on out_* exactly one cycle after acceptance when the block was empty. Payload and ctrl move together with no reordering.
- SKID=0:
  - in_ready = out_ready || !out_valid.
  - The main register loads on accept.
  - A simultaneous consume and accept gives full throughput, 1 entry/cycle.
- SKID=1, state machine on occupancy:
  - EMPTY(0): in_ready=1. An accept moves to ONE and loads main.
  - ONE(1): in_ready=1.
    - Accept and consume together: stay in ONE, main <= input.
    - Accept only: go to TWO; the input is written to the skid slot, main holds.
    - Consume only: go to EMPTY.
  - TWO(2): in_ready=0 (registered).
    - Consume: go to ONE, main <= skid.
    - Otherwise hold.
  - An accept in TWO is impossible because in_ready=0. If in_valid is high anyway, the block ignores it.
- out_valid = (occupancy != 0). out_ctrl is masked to 0 when out_valid=0 so that a bubble never asserts regwrite or memwrite downstream.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_ctrl remain bit-stable.
- occupancy is a registered output and is updated on the same edge as the state.

Decomposition:
- Shared package pipe_pkg holds:
  - ex_mem_ctrl_t, a packed struct of branch, memread, memtoreg, memwrite, regwrite, addermuxselect and zero.
  - Width constants XLEN=64, REG_ADDR_W=5, EXMEM_DATA_W=197, EXMEM_CTRL_W=7.
- Each stage instantiates pipe_stage_reg with the packed widths from pipe_pkg.
- One natural sub-module: pipe_skid_slot, the single-entry holding register with valid and load/clear, instantiated twice when SKID=1.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset 2 cycles, in_valid=0.
  - Expected: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 on the cycle after reset deasserts.
- Streaming:
  - Stimulus: out_ready=1, in_data = 1, 2, 3, 4 over four consecutive cycles with in_ctrl=7'h10.
  - Expected: out_data = 1, 2, 3, 4 one cycle later each, out_ctrl=7'h10, occupancy stays 1.
- Back-pressure with SKID=1:
  - Stimulus: out_ready=0, send 0xA then 0xB.
  - Expected:
    - occupancy goes 1 then 2; in_ready=0.
    - 0xC is held upstream and not accepted.
    - After raising out_ready, outputs are 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush while full:
  - Stimulus: occupancy=2, assert flush together with in_valid=1 carrying 0xD.
  - Expected:
    - Next cycle: out_valid=0, out_ctrl=0 (regwrite=0), occupancy=0.
    - 0xD never appears on out_data.
- Reset mid-stall:
  - Stimulus: occupancy=2, out_ready=0, assert reset for 1 cycle.
  - Expected: all entries dropped; with CLEAR_DATA=1, out_data=0 the next cycle.
- SKID=0 ready path:
  - Stimulus: out_valid=1, toggle out_ready.
  - Expected: in_ready follows out_ready in the same cycle; no accept happens when both out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and bundle types for the RV64 inter-stage pipeline registers.
// Stage wrappers size pipe_stage_reg from these constants.
package pipe_pkg;

   localparam int XLEN         = 64;
   localparam int REG_ADDR_W   = 5;
   localparam int EXMEM_DATA_W = 3 * XLEN + REG_ADDR_W;
   localparam int EXMEM_CTRL_W = 7;

   typedef struct packed {
      logic branch;
      logic memread;
      logic memtoreg;
      logic memwrite;
      logic regwrite;
      logic addermuxselect;
      logic zero;
   } ex_mem_ctrl_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single-entry holding register: clear beats load, load beats unload.
// The data payload is only zeroed on clear when CLEAR_DATA is set.
module pipe_skid_slot #(
   parameter int DATA_W     = 1,
   parameter int CTRL_W     = 1,
   parameter bit CLEAR_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              load,
   input  logic              unload,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   always_ff @(posedge clk) begin
      if (clear) begin
         valid  <= 1'b0;
         q_ctrl <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         q_ctrl <= d_ctrl;
      end else if (unload) begin
         valid  <= 1'b0;
         q_ctrl <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         if (CLEAR_DATA)
            q_data <= '0;
      end else if (load) begin
         q_data <= d_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush and optional skid slot.
// SKID=1 registers in_ready so no combinational ready path crosses stages.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = EXMEM_DATA_W,
   parameter int CTRL_W     = EXMEM_CTRL_W,
   parameter bit SKID       = 1'b1,
   parameter bit CLEAR_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   logic              clear;
   logic              acc;
   logic              cons;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [CTRL_W-1:0] m_ctrl;

   // A flush cycle neither accepts nor consumes.
   assign clear = reset || flush;
   assign acc   = in_valid && in_ready && !flush;
   assign cons  = out_valid && out_ready && !flush;

   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign out_ctrl  = m_valid ? m_ctrl : '0;

   generate
      if (SKID) begin : g_skid
         occ_t              state;
         occ_t              state_nxt;
         logic              ld_main;
         logic              ul_main;
         logic              ld_skid;
         logic              ul_skid;
         logic              from_skid;
         logic              s_valid;
         logic [DATA_W-1:0] s_data;
         logic [CTRL_W-1:0] s_ctrl;

         always_ff @(posedge clk) begin
            if (clear)
               state <= OCC_EMPTY;
            else
               state <= state_nxt;
         end

         always_comb begin
            state_nxt = state;
            unique case (state)
               OCC_EMPTY: if (acc) state_nxt = OCC_ONE;
               OCC_ONE: begin
                  if (acc && !cons)
                     state_nxt = OCC_TWO;
                  else if (!acc && cons)
                     state_nxt = OCC_EMPTY;
               end
               OCC_TWO: if (cons) state_nxt = OCC_ONE;
               default: state_nxt = OCC_EMPTY;
            endcase
         end

         always_comb begin
            ld_main   = 1'b0;
            ul_main   = 1'b0;
            ld_skid   = 1'b0;
            ul_skid   = 1'b0;
            from_skid = 1'b0;
            unique case (state)
               OCC_EMPTY: ld_main = acc;
               OCC_ONE: begin
                  ld_main = acc && cons;
                  ul_main = cons && !acc;
                  ld_skid = acc && !cons;
               end
               OCC_TWO: begin
                  ld_main   = cons;
                  from_skid = cons;
                  ul_skid   = cons;
               end
               default: ;
            endcase
         end

         pipe_skid_slot #(
            .DATA_W     (DATA_W),
            .CTRL_W     (CTRL_W),
            .CLEAR_DATA (CLEAR_DATA)
         ) u_main (
            .clk    (clk),
            .clear  (clear),
            .load   (ld_main),
            .unload (ul_main),
            .d_data (from_skid ? s_data : in_data),
            .d_ctrl (from_skid ? s_ctrl : in_ctrl),
            .valid  (m_valid),
            .q_data (m_data),
            .q_ctrl (m_ctrl)
         );

         pipe_skid_slot #(
            .DATA_W     (DATA_W),
            .CTRL_W     (CTRL_W),
            .CLEAR_DATA (CLEAR_DATA)
         ) u_skid (
            .clk    (clk),
            .clear  (clear),
            .load   (ld_skid),
            .unload (ul_skid),
            .d_data (in_data),
            .d_ctrl (in_ctrl),
            .valid  (s_valid),
            .q_data (s_data),
            .q_ctrl (s_ctrl)
         );

         // The skid slot is full exactly in TWO, so this is a flop output.
         assign in_ready  = !s_valid;
         assign occupancy = state;
      end else begin : g_single
         pipe_skid_slot #(
            .DATA_W     (DATA_W),
            .CTRL_W     (CTRL_W),
            .CLEAR_DATA (CLEAR_DATA)
         ) u_main (
            .clk    (clk),
            .clear  (clear),
            .load   (acc),
            .unload (cons && !acc),
            .d_data (in_data),
            .d_ctrl (in_ctrl),
            .valid  (m_valid),
            .q_data (m_data),
            .q_ctrl (m_ctrl)
         );

         assign in_ready  = out_ready || !m_valid;
         assign occupancy = {1'b0, m_valid};
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CLEAR_DATA=1 instance and a SKID=0
// instance, checked by directed scenarios and a queue-based random model.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;

   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [196:0] in_data = '0;
   logic [6:0]   in_ctrl = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [196:0] out_data;
   logic [6:0]   out_ctrl;
   logic [1:0]   occupancy;

   logic         in_valid0 = 1'b0;
   logic         in_ready0;
   logic [15:0]  in_data0 = '0;
   logic [6:0]   in_ctrl0 = '0;
   logic         out_valid0;
   logic         out_ready0 = 1'b0;
   logic [15:0]  out_data0;
   logic [6:0]   out_ctrl0;
   logic [1:0]   occupancy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W     (197),
      .CTRL_W     (7),
      .SKID       (1'b1),
      .CLEAR_DATA (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );

   pipe_stage_reg #(
      .DATA_W     (16),
      .CTRL_W     (7),
      .SKID       (1'b0),
      .CLEAR_DATA (1'b0)
   ) dut0 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .in_data   (in_data0),
      .in_ctrl   (in_ctrl0),
      .out_valid (out_valid0),
      .out_ready (out_ready0),
      .out_data  (out_data0),
      .out_ctrl  (out_ctrl0),
      .occupancy (occupancy0)
   );

   // Reference: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
   typedef struct packed {
      logic [196:0] d;
      logic [6:0]   c;
   } e1_t;
   typedef struct packed {
      logic [15:0] d;
      logic [6:0]  c;
   } e0_t;
   e1_t q1[$];
   e0_t q0[$];

   always @(posedge clk) begin : model
      bit c1, a1, c0, a0;
      c1 = q1.size() > 0 && out_ready;
      a1 = in_valid && q1.size() < 2;
      c0 = q0.size() > 0 && out_ready0;
      a0 = in_valid0 && (out_ready0 || q0.size() == 0);
      if (reset || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (c1) void'(q1.pop_front());
         if (a1) q1.push_back(e1_t'{d: in_data, c: in_ctrl});
         if (c0) void'(q0.pop_front());
         if (a0) q0.push_back(e0_t'{d: in_data0, c: in_ctrl0});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
      end
      checks++;
      if (out_ctrl !== 7'h0) begin
         errors++; $display("FAIL reset_out_ctrl: got %0h want 0", out_ctrl);
      end
      checks++;
      if (occupancy !== 2'd0) begin
         errors++; $display("FAIL reset_occ: got %0d want 0", occupancy);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      end
      checks++;
      if (out_data !== 197'h0) begin
         errors++; $display("FAIL reset_out_data: got %0h want 0", out_data);
      end
      checks++;
      if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_skid0: got v=%0b occ=%0d rdy=%0b want 0 0 1",
                  out_valid0, occupancy0, in_ready0);
      end
      step();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data  = 197'(i);
         in_ctrl  = 7'h10;
         @(negedge clk);
         if (i > 1) begin
            checks++;
            if (out_data !== 197'(i - 1) || out_ctrl !== 7'h10 || occupancy !== 2'd1) begin
               errors++;
               $display("FAIL stream_%0d: got d=%0h c=%0h occ=%0d want d=%0h c=10 occ=1",
                        i - 1, out_data, out_ctrl, occupancy, i - 1);
            end
         end
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_data !== 197'd4 || out_ctrl !== 7'h10 || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL stream_4: got d=%0h c=%0h occ=%0d want d=4 c=10 occ=1",
                  out_data, out_ctrl, occupancy);
      end
      step();
      @(negedge clk);
      checks++;
      if (occupancy !== 2'd0 || out_ctrl !== 7'h0) begin
         errors++;
         $display("FAIL stream_drain: got occ=%0d c=%0h want 0 0", occupancy, out_ctrl);
      end
      step();
   endtask

   task automatic test_back_pressure();
      logic [15:0] got[$];
      bit          c_acc;
      bit          taken = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 7'h0a;
      in_data   = 197'ha;
      step();
      in_data = 197'hb;
      @(negedge clk);
      checks++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 197'ha) begin
         errors++;
         $display("FAIL bp_one: got occ=%0d rdy=%0b d=%0h want 1 1 a",
                  occupancy, in_ready, out_data);
      end
      step();
      in_data = 197'hc;
      @(negedge clk);
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 197'ha) begin
         errors++;
         $display("FAIL bp_two: got occ=%0d rdy=%0b d=%0h want 2 0 a",
                  occupancy, in_ready, out_data);
      end
      step();
      @(negedge clk);
      checks++;
      if (occupancy !== 2'd2 || out_data !== 197'ha || out_ctrl !== 7'h0a) begin
         errors++;
         $display("FAIL bp_hold: got occ=%0d d=%0h c=%0h want 2 a 0a",
                  occupancy, out_data, out_ctrl);
      end
      step();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) got.push_back(out_data[15:0]);
         c_acc = in_valid && in_ready;
         step();
         if (c_acc) begin
            in_valid = 1'b0;
            taken = 1'b1;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (!taken) begin
         errors++; $display("FAIL bp_c_accept: got not accepted want accepted");
      end
      checks++;
      if (got.size() != 3) begin
         errors++; $display("FAIL bp_count: got %0d want 3", got.size());
      end else begin
         checks++;
         if (got[0] !== 16'ha || got[1] !== 16'hb || got[2] !== 16'hc) begin
            errors++;
            $display("FAIL bp_order: got %0h %0h %0h want a b c", got[0], got[1], got[2]);
         end
      end
   endtask

   task automatic test_flush_full();
      bit seen_d = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 7'h04;
      in_data   = 197'h11;
      step();
      in_data = 197'h12;
      step();
      in_data = 197'hd;
      flush   = 1'b1;
      @(negedge clk);
      checks++;
      if (occupancy !== 2'd2) begin
         errors++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy);
      end
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 7'h0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL flush_state: got v=%0b c=%0h occ=%0d want 0 0 0",
                  out_valid, out_ctrl, occupancy);
      end
      checks++;
      if (out_data !== 197'h0) begin
         errors++; $display("FAIL flush_data: got %0h want 0", out_data);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (out_valid || out_data === 197'hd) seen_d = 1'b1;
         step();
      end
      checks++;
      if (seen_d) begin
         errors++; $display("FAIL flush_drop: got entry after flush want none");
      end
   endtask

   task automatic test_reset_stall();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 7'h7f;
      in_data   = 197'h21;
      step();
      in_data = 197'h22;
      step();
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_stall_state: got v=%0b occ=%0d rdy=%0b want 0 0 1",
                  out_valid, occupancy, in_ready);
      end
      checks++;
      if (out_data !== 197'h0 || out_ctrl !== 7'h0) begin
         errors++;
         $display("FAIL rst_stall_data: got d=%0h c=%0h want 0 0", out_data, out_ctrl);
      end
      step();
   endtask

   task automatic test_skid0_ready();
      out_ready0 = 1'b0;
      in_valid0  = 1'b1;
      in_ctrl0   = 7'h04;
      in_data0   = 16'h1234;
      step();
      in_data0 = 16'h5678;
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_data0 !== 16'h1234) begin
         errors++;
         $display("FAIL s0_stall: got v=%0b rdy=%0b d=%0h want 1 0 1234",
                  out_valid0, in_ready0, out_data0);
      end
      step();
      @(negedge clk);
      checks++;
      if (out_data0 !== 16'h1234 || occupancy0 !== 2'd1 || out_ctrl0 !== 7'h04) begin
         errors++;
         $display("FAIL s0_no_accept: got d=%0h occ=%0d c=%0h want 1234 1 04",
                  out_data0, occupancy0, out_ctrl0);
      end
      out_ready0 = 1'b1;
      #1;
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++; $display("FAIL s0_ready_follow_hi: got %0b want 1", in_ready0);
      end
      step();
      in_valid0  = 1'b0;
      out_ready0 = 1'b0;
      #1;
      checks++;
      if (in_ready0 !== 1'b0) begin
         errors++; $display("FAIL s0_ready_follow_lo: got %0b want 0", in_ready0);
      end
      @(negedge clk);
      checks++;
      if (out_data0 !== 16'h5678 || occupancy0 !== 2'd1) begin
         errors++;
         $display("FAIL s0_throughput: got d=%0h occ=%0d want 5678 1", out_data0, occupancy0);
      end
      out_ready0 = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [223:0] r;
      for (int n = 0; n < 400; n++) begin
         r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         in_data    = r[196:0];
         in_ctrl    = 7'($urandom);
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         in_data0   = 16'($urandom);
         in_ctrl0   = 7'($urandom);
         in_valid0  = ($urandom_range(0, 3) != 0);
         out_ready0 = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         reset      = ($urandom_range(0, 59) == 0);
         @(negedge clk);
         checks++;
         if (out_valid !== (q1.size() != 0) || occupancy !== 2'(q1.size())
             || in_ready !== (q1.size() < 2)) begin
            errors++;
            $display("FAIL rnd1_state@%0d: got v=%0b occ=%0d rdy=%0b want occ=%0d",
                     n, out_valid, occupancy, in_ready, q1.size());
         end
         checks++;
         if (q1.size() == 0 ? out_ctrl !== 7'h0
             : (out_ctrl !== q1[0].c || out_data !== q1[0].d)) begin
            errors++;
            $display("FAIL rnd1_payload@%0d: got c=%0h d=%0h", n, out_ctrl, out_data);
         end
         checks++;
         if (out_valid0 !== (q0.size() != 0) || occupancy0 !== 2'(q0.size())
             || in_ready0 !== (out_ready0 || q0.size() == 0)) begin
            errors++;
            $display("FAIL rnd0_state@%0d: got v=%0b occ=%0d rdy=%0b want occ=%0d",
                     n, out_valid0, occupancy0, in_ready0, q0.size());
         end
         checks++;
         if (q0.size() == 0 ? out_ctrl0 !== 7'h0
             : (out_ctrl0 !== q0[0].c || out_data0 !== q0[0].d)) begin
            errors++;
            $display("FAIL rnd0_payload@%0d: got c=%0h d=%0h", n, out_ctrl0, out_data0);
         end
         step();
      end
      flush     = 1'b0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_valid0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush_full();
      test_reset_stall();
      test_skid0_ready();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
